// File: rtl/layer_sequencer.sv
// Per-layer descriptor scheduler: walks a programmable table of channel masks and
// repeat counts, one descriptor per io_layerEnd, for a finite or unbounded number of passes.
module layer_sequencer #(
   parameter int NUM_CH     = 8,
   parameter int MAX_LAYERS = 16,
   parameter int IDX_W      = 4,
   parameter int CNT_W      = 16
) (
   input  logic              io_clk,
   input  logic              io_rst,
   input  logic              io_start,
   input  logic              io_abort,
   input  logic [IDX_W:0]    io_numLayers,
   input  logic [CNT_W-1:0]  io_programLoops,
   input  logic              io_cfgWrEn,
   input  logic [IDX_W-1:0]  io_cfgWrAddr,
   input  logic [NUM_CH-1:0] io_cfgWrMask,
   input  logic [CNT_W-1:0]  io_cfgWrRepeat,
   input  logic              io_cfgWrBase,
   input  logic              io_layerEnd,
   output logic [NUM_CH-1:0] io_layerCfg,
   output logic [CNT_W-1:0]  io_layerCnt,
   output logic              io_BaseLayer,
   output logic [IDX_W-1:0]  io_layerIdx,
   output logic [CNT_W-1:0]  io_loopCount,
   output logic              io_busy,
   output logic              io_done,
   output logic              io_cfgErr
);

   typedef struct packed {
      logic [NUM_CH-1:0] mask;
      logic [CNT_W-1:0]  rep;
      logic              base;
   } desc_t;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   localparam logic [IDX_W:0] NL_MAX  = (IDX_W+1)'(MAX_LAYERS);
   localparam logic [IDX_W:0] NL_ONE  = (IDX_W+1)'(1);
   localparam logic [CNT_W:0] LC_ONE  = (CNT_W+1)'(1);

   desc_t             tbl_q [MAX_LAYERS];
   desc_t             tbl_d [MAX_LAYERS];
   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  loop_cnt_q, loop_cnt_d;
   logic [CNT_W-1:0]  loops_q, loops_d;
   logic [IDX_W:0]    num_layers_q, num_layers_d;
   logic [NUM_CH-1:0] cfg_q, cfg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              base_q, base_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   desc_t             nxt;
   logic              wr_ok, start_ok, last_layer, last_loop;

   always_comb begin
      tbl_d        = tbl_q;
      state_d      = state_q;
      idx_d        = idx_q;
      loop_cnt_d   = loop_cnt_q;
      loops_d      = loops_q;
      num_layers_d = num_layers_q;

      // table is only writable while idle so the combinational read never races a write
      wr_ok = io_cfgWrEn && (state_q == IDLE) && ({1'b0, io_cfgWrAddr} < NL_MAX);
      err_d = io_cfgWrEn && !wr_ok;
      if (wr_ok) begin
         tbl_d[io_cfgWrAddr] = '{mask: io_cfgWrMask, rep: io_cfgWrRepeat, base: io_cfgWrBase};
      end

      start_ok   = (io_numLayers != '0) && (io_numLayers <= NL_MAX);
      last_layer = ({1'b0, idx_q} == (num_layers_q - NL_ONE));
      last_loop  = (loops_q != '0) && (({1'b0, loop_cnt_q} + LC_ONE) == {1'b0, loops_q});

      case (state_q)
         IDLE: begin
            if (io_start) begin
               if (start_ok) begin
                  state_d      = LOAD;
                  idx_d        = '0;
                  loop_cnt_d   = '0;
                  num_layers_d = io_numLayers;
                  loops_d      = io_programLoops;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD: state_d = RUN;
         RUN: begin
            if (io_layerEnd) begin
               if (!last_layer) begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = LOAD;
               end else begin
                  loop_cnt_d = (loop_cnt_q == '1) ? loop_cnt_q : loop_cnt_q + CNT_W'(1);
                  if (last_loop) begin
                     state_d = DONE;
                  end else begin
                     idx_d   = '0;
                     state_d = LOAD;
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // abort overrides whatever the active state decided, including a same-cycle layer end
      if (io_abort && (state_q != IDLE)) begin
         state_d    = IDLE;
         idx_d      = idx_q;
         loop_cnt_d = loop_cnt_q;
      end

      // outputs are registered from the next state, so LOAD shows the new count one cycle
      // after io_layerEnd and the mask only appears once RUN is entered
      nxt    = tbl_q[idx_d];
      cnt_d  = cnt_q;
      base_d = base_q;
      if (state_d == LOAD) begin
         cnt_d  = nxt.rep;
         base_d = nxt.base;
      end
      cfg_d  = (state_d == RUN) ? nxt.mask : '0;
      done_d = (state_d == DONE);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         tbl_q        <= '{default: '0};
         state_q      <= IDLE;
         idx_q        <= '0;
         loop_cnt_q   <= '0;
         loops_q      <= '0;
         num_layers_q <= '0;
         cfg_q        <= '0;
         cnt_q        <= '0;
         base_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         tbl_q        <= tbl_d;
         state_q      <= state_d;
         idx_q        <= idx_d;
         loop_cnt_q   <= loop_cnt_d;
         loops_q      <= loops_d;
         num_layers_q <= num_layers_d;
         cfg_q        <= cfg_d;
         cnt_q        <= cnt_d;
         base_q       <= base_d;
         done_q       <= done_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
      end
   end

   assign io_layerCfg  = cfg_q;
   assign io_layerCnt  = cnt_q;
   assign io_BaseLayer = base_q;
   assign io_layerIdx  = idx_q;
   assign io_loopCount = loop_cnt_q;
   assign io_busy      = busy_q;
   assign io_done      = done_q;
   assign io_cfgErr    = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: expected descriptors are queued at program start and
// popped as each LOAD/RUN pair is observed.
module tb_layer_sequencer;
   localparam int NUM_CH = 8, MAX_LAYERS = 16, IDX_W = 4, CNT_W = 16;

   logic              io_clk = 1'b0;
   logic              io_rst;
   logic              io_start, io_abort, io_cfgWrEn, io_cfgWrBase, io_layerEnd;
   logic [IDX_W:0]    io_numLayers;
   logic [CNT_W-1:0]  io_programLoops, io_cfgWrRepeat;
   logic [IDX_W-1:0]  io_cfgWrAddr;
   logic [NUM_CH-1:0] io_cfgWrMask;
   logic [NUM_CH-1:0] io_layerCfg;
   logic [CNT_W-1:0]  io_layerCnt, io_loopCount;
   logic              io_BaseLayer, io_busy, io_done, io_cfgErr;
   logic [IDX_W-1:0]  io_layerIdx;

   layer_sequencer #(.NUM_CH(NUM_CH), .MAX_LAYERS(MAX_LAYERS), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .io_clk(io_clk), .io_rst(io_rst), .io_start(io_start), .io_abort(io_abort),
      .io_numLayers(io_numLayers), .io_programLoops(io_programLoops),
      .io_cfgWrEn(io_cfgWrEn), .io_cfgWrAddr(io_cfgWrAddr), .io_cfgWrMask(io_cfgWrMask),
      .io_cfgWrRepeat(io_cfgWrRepeat), .io_cfgWrBase(io_cfgWrBase), .io_layerEnd(io_layerEnd),
      .io_layerCfg(io_layerCfg), .io_layerCnt(io_layerCnt), .io_BaseLayer(io_BaseLayer),
      .io_layerIdx(io_layerIdx), .io_loopCount(io_loopCount), .io_busy(io_busy),
      .io_done(io_done), .io_cfgErr(io_cfgErr));

   always #5 io_clk = ~io_clk;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [NUM_CH-1:0] mask;
      logic [CNT_W-1:0]  cnt;
      logic              base;
   } exp_t;

   exp_t              exp_q[$];
   logic [NUM_CH-1:0] m_mask [MAX_LAYERS];
   logic [CNT_W-1:0]  m_rep  [MAX_LAYERS];
   logic              m_base [MAX_LAYERS];
   int                checks = 0, errors = 0;

   task automatic tick();
      @(negedge io_clk);
   endtask

   task automatic push_entry(input int i);
      exp_t e;
      e.idx = IDX_W'(i); e.mask = m_mask[i]; e.cnt = m_rep[i]; e.base = m_base[i];
      exp_q.push_back(e);
   endtask

   task automatic push_prog(input int nl, input int loops);
      for (int l = 0; l < loops; l++)
         for (int i = 0; i < nl; i++) push_entry(i);
   endtask

   task automatic cfg_write(input int addr, input logic [NUM_CH-1:0] m, input logic [CNT_W-1:0] r,
                            input logic b, input logic exp_err);
      io_cfgWrEn = 1'b1; io_cfgWrAddr = IDX_W'(addr);
      io_cfgWrMask = m; io_cfgWrRepeat = r; io_cfgWrBase = b;
      tick();
      io_cfgWrEn = 1'b0;
      checks++;
      if (io_cfgErr !== exp_err) begin
         errors++; $display("FAIL cfg_write_err addr=%0d: got %b want %b", addr, io_cfgErr, exp_err);
      end
      if (!exp_err) begin m_mask[addr] = m; m_rep[addr] = r; m_base[addr] = b; end
   endtask

   task automatic do_start(input logic [IDX_W:0] nl, input logic [CNT_W-1:0] lp);
      io_start = 1'b1; io_numLayers = nl; io_programLoops = lp;
      tick();
      io_start = 1'b0;
   endtask

   // Entered on the LOAD cycle; checks the guard cycle, then RUN, then optionally ends the layer.
   task automatic step_layer(input int hold, input bit do_end);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++; $display("FAIL scoreboard_empty: got 0 entries want >=1");
         return;
      end
      e = exp_q.pop_front();
      checks += 5;
      if (io_layerIdx !== e.idx) begin errors++; $display("FAIL load_idx: got %0d want %0d", io_layerIdx, e.idx); end
      if (io_layerCnt !== e.cnt) begin errors++; $display("FAIL load_cnt: got %0d want %0d", io_layerCnt, e.cnt); end
      if (io_BaseLayer !== e.base) begin errors++; $display("FAIL load_base: got %b want %b", io_BaseLayer, e.base); end
      if (io_layerCfg !== '0) begin errors++; $display("FAIL load_guard_cfg: got %h want 00", io_layerCfg); end
      if (io_busy !== 1'b1 || io_done !== 1'b0) begin
         errors++; $display("FAIL load_busy_done: got busy=%b done=%b want 1 0", io_busy, io_done);
      end
      tick();
      checks += 2;
      if (io_layerCfg !== e.mask) begin errors++; $display("FAIL run_cfg idx=%0d: got %h want %h", e.idx, io_layerCfg, e.mask); end
      if (io_layerCnt !== e.cnt) begin errors++; $display("FAIL run_cnt: got %0d want %0d", io_layerCnt, e.cnt); end
      for (int h = 0; h < hold; h++) begin
         tick();
         checks++;
         if (io_layerCfg !== e.mask) begin errors++; $display("FAIL run_hold_cfg: got %h want %h", io_layerCfg, e.mask); end
      end
      if (do_end) begin
         io_layerEnd = 1'b1;
         tick();
         io_layerEnd = 1'b0;
      end
   endtask

   task automatic test_reset();
      io_rst = 1'b1;
      io_start = 0; io_abort = 0; io_cfgWrEn = 0; io_layerEnd = 0; io_cfgWrBase = 0;
      io_numLayers = '0; io_programLoops = '0; io_cfgWrAddr = '0; io_cfgWrMask = '0; io_cfgWrRepeat = '0;
      for (int i = 0; i < MAX_LAYERS; i++) begin m_mask[i] = '0; m_rep[i] = '0; m_base[i] = 1'b0; end
      tick(); tick();
      checks++;
      if ({io_layerCfg, io_layerCnt, io_BaseLayer, io_layerIdx, io_loopCount, io_busy, io_done, io_cfgErr} !== '0) begin
         errors++; $display("FAIL reset_outputs: got cfg=%h cnt=%0d busy=%b want all 0", io_layerCfg, io_layerCnt, io_busy);
      end
      io_rst = 1'b0;
      tick();
   endtask

   task automatic test_single_pass();
      cfg_write(0, 8'h01, 16'd2, 1'b0, 1'b0);
      cfg_write(1, 8'h06, 16'd1, 1'b0, 1'b0);
      cfg_write(2, 8'h80, 16'd3, 1'b1, 1'b0);
      do_start(5'd3, 16'd1);
      push_prog(3, 1);
      checks++;
      if (io_loopCount !== '0) begin errors++; $display("FAIL single_start_loop: got %0d want 0", io_loopCount); end
      step_layer(1, 1'b1);
      step_layer(0, 1'b1);
      step_layer(2, 1'b1);
      checks += 2;
      if (io_done !== 1'b1 || io_layerCfg !== '0) begin
         errors++; $display("FAIL single_done: got done=%b cfg=%h want 1 00", io_done, io_layerCfg);
      end
      if (io_loopCount !== 16'd1) begin errors++; $display("FAIL single_loops: got %0d want 1", io_loopCount); end
      tick();
      checks += 2;
      if (io_busy !== 1'b0 || io_done !== 1'b0) begin
         errors++; $display("FAIL single_idle: got busy=%b done=%b want 0 0", io_busy, io_done);
      end
      if (io_layerIdx !== 4'd2 || io_loopCount !== 16'd1) begin
         errors++; $display("FAIL single_hold: got idx=%0d loops=%0d want 2 1", io_layerIdx, io_loopCount);
      end
   endtask

   task automatic test_multi_loop();
      do_start(5'd2, 16'd2);
      push_prog(2, 2);
      step_layer(0, 1'b1);
      step_layer(1, 1'b1);
      checks++;
      if (io_loopCount !== 16'd1) begin errors++; $display("FAIL multi_mid_loops: got %0d want 1", io_loopCount); end
      step_layer(0, 1'b1);
      step_layer(0, 1'b1);
      checks += 2;
      if (io_done !== 1'b1) begin errors++; $display("FAIL multi_done: got %b want 1", io_done); end
      if (io_loopCount !== 16'd2) begin errors++; $display("FAIL multi_loops: got %0d want 2", io_loopCount); end
      tick();
      checks++;
      if (io_busy !== 1'b0) begin errors++; $display("FAIL multi_idle: got busy=%b want 0", io_busy); end
   endtask

   task automatic test_infinite_abort();
      do_start(5'd1, 16'd0);
      for (int i = 0; i < 5; i++) push_entry(0);
      for (int i = 0; i < 5; i++) step_layer(0, 1'b1);
      checks += 2;
      if (io_loopCount !== 16'd5) begin errors++; $display("FAIL inf_loops: got %0d want 5", io_loopCount); end
      if (io_done !== 1'b0 || io_busy !== 1'b1) begin
         errors++; $display("FAIL inf_running: got done=%b busy=%b want 0 1", io_done, io_busy);
      end
      tick();
      checks++;
      if (io_layerCfg !== 8'h01) begin errors++; $display("FAIL inf_run_cfg: got %h want 01", io_layerCfg); end
      io_abort = 1'b1;
      tick();
      io_abort = 1'b0;
      checks += 2;
      if (io_busy !== 1'b0 || io_layerCfg !== '0 || io_done !== 1'b0) begin
         errors++; $display("FAIL inf_abort: got busy=%b cfg=%h done=%b want 0 00 0", io_busy, io_layerCfg, io_done);
      end
      if (io_loopCount !== 16'd5) begin errors++; $display("FAIL inf_abort_hold: got %0d want 5", io_loopCount); end
      tick();
      checks++;
      if (io_done !== 1'b0) begin errors++; $display("FAIL inf_no_done: got %b want 0", io_done); end
   endtask

   task automatic test_cfg_errors();
      logic [IDX_W:0] bad [2];
      bad[0] = 5'd0; bad[1] = 5'd17;
      for (int k = 0; k < 2; k++) begin
         do_start(bad[k], 16'd1);
         checks += 2;
         if (io_cfgErr !== 1'b1) begin errors++; $display("FAIL bad_start_err nl=%0d: got %b want 1", bad[k], io_cfgErr); end
         if (io_busy !== 1'b0) begin errors++; $display("FAIL bad_start_busy nl=%0d: got %b want 0", bad[k], io_busy); end
         tick();
         checks++;
         if (io_cfgErr !== 1'b0 || io_busy !== 1'b0) begin
            errors++; $display("FAIL bad_start_after: got err=%b busy=%b want 0 0", io_cfgErr, io_busy);
         end
      end
      do_start(5'd1, 16'd1);
      tick();
      cfg_write(0, 8'hFF, 16'd9, 1'b1, 1'b1);
      io_layerEnd = 1'b1;
      tick();
      io_layerEnd = 1'b0;
      checks++;
      if (io_done !== 1'b1) begin errors++; $display("FAIL busy_write_done: got %b want 1", io_done); end
      tick();
      do_start(5'd1, 16'd1);
      push_entry(0);
      step_layer(0, 1'b1);
      checks++;
      if (io_done !== 1'b1) begin errors++; $display("FAIL rerun_done: got %b want 1", io_done); end
      tick();
   endtask

   task automatic test_abort_vs_end();
      do_start(5'd2, 16'd1);
      push_prog(2, 1);
      step_layer(0, 1'b1);
      step_layer(0, 1'b0);
      io_abort = 1'b1; io_layerEnd = 1'b1; io_start = 1'b1; io_numLayers = 5'd2;
      tick();
      io_abort = 1'b0; io_layerEnd = 1'b0; io_start = 1'b0;
      checks += 2;
      if (io_busy !== 1'b0 || io_done !== 1'b0 || io_layerCfg !== '0) begin
         errors++; $display("FAIL abort_end: got busy=%b done=%b cfg=%h want 0 0 00", io_busy, io_done, io_layerCfg);
      end
      if (io_cfgErr !== 1'b0) begin errors++; $display("FAIL busy_start_err: got %b want 0", io_cfgErr); end
      tick();
      checks++;
      if (io_done !== 1'b0 || io_busy !== 1'b0) begin
         errors++; $display("FAIL abort_end_after: got done=%b busy=%b want 0 0", io_done, io_busy);
      end
   endtask

   task automatic test_async_reset();
      cfg_write(0, 8'h3C, 16'd7, 1'b1, 1'b0);
      do_start(5'd1, 16'd0);
      push_entry(0);
      step_layer(0, 1'b0);
      #2 io_rst = 1'b1;
      #1;
      checks++;
      if ({io_layerCfg, io_layerCnt, io_BaseLayer, io_layerIdx, io_loopCount, io_busy, io_done, io_cfgErr} !== '0) begin
         errors++; $display("FAIL async_reset: got cfg=%h cnt=%0d busy=%b want all 0", io_layerCfg, io_layerCnt, io_busy);
      end
      tick();
      io_rst = 1'b0;
      for (int i = 0; i < MAX_LAYERS; i++) begin m_mask[i] = '0; m_rep[i] = '0; m_base[i] = 1'b0; end
      tick();
      do_start(5'd1, 16'd1);
      push_entry(0);
      step_layer(1, 1'b1);
      checks++;
      if (io_done !== 1'b1 || io_layerCfg !== '0 || io_layerCnt !== '0) begin
         errors++; $display("FAIL zero_table_done: got done=%b cfg=%h cnt=%0d want 1 00 0", io_done, io_layerCfg, io_layerCnt);
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_pass();
      test_multi_loop();
      test_infinite_abort();
      test_cfg_errors();
      test_abort_vs_end();
      test_async_reset();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Programmable scheduler for the per-layer trigger counter.
- Holds a table of up to MAX_LAYERS layer descriptors: channel mask, repeat count and base-layer flag.
- On start, presents one descriptor at a time to the counter as io_layerCfg, io_layerCnt and io_BaseLayer, and advances to the next descriptor on each io_layerEnd.
- Repeats the whole program io_programLoops times, or forever when that input is 0, then signals done.

Parameters:
- NUM_CH, 8: trigger channels; width of the layer mask.
- MAX_LAYERS, 16: descriptor table depth.
- IDX_W, 4: layer index width; equals clog2(MAX_LAYERS).
- CNT_W, 16: width of the repeat and loop counters.

Ports:
- io_clk  in  1  clock.
- io_rst  in  1  reset; asynchronous, active-high.
- io_start  in  1  single-cycle pulse; begins the program.
- io_abort  in  1  single-cycle pulse; stops the program immediately.
- io_numLayers  in  IDX_W+1  number of active table entries, legal range 1..MAX_LAYERS.
- io_programLoops  in  CNT_W  number of full program passes; 0 means infinite.
- io_cfgWrEn  in  1  table write strobe.
- io_cfgWrAddr  in  IDX_W  table write address.
- io_cfgWrMask  in  NUM_CH  channel mask written to the entry.
- io_cfgWrRepeat  in  CNT_W  repeat count written to the entry.
- io_cfgWrBase  in  1  base-layer flag written to the entry.
- io_layerEnd  in  1  pulse from the layer counter: current layer complete.
- io_layerCfg  out  NUM_CH  mask driven to the counter.
- io_layerCnt  out  CNT_W  repeat count driven to the counter.
- io_BaseLayer  out  1  base-layer flag driven to the counter.
- io_layerIdx  out  IDX_W  index of the current descriptor.
- io_loopCount  out  CNT_W  number of completed program passes.
- io_busy  out  1  high in every state except IDLE.
- io_done  out  1  1-cycle pulse when the final pass completes.
- io_cfgErr  out  1  1-cycle pulse on a rejected write or rejected start.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - All table entries are cleared to 0.
  - All outputs are 0.
  - Internal registers: latched numLayers = 0, latched loops = 0.
- Table writes:
  - Accepted only in IDLE, on the cycle io_cfgWrEn=1; the entry is updated the next cycle.
  - A write in any other state is dropped and io_cfgErr pulses the following cycle.
  - io_cfgWrAddr >= MAX_LAYERS is dropped and pulses io_cfgErr.
- FSM states:
  - IDLE:
    - On io_start with io_numLayers in 1..MAX_LAYERS: latch io_numLayers and io_programLoops, set idx=0, loopCount=0, go to LOAD.
    - An illegal io_numLayers (0 or > MAX_LAYERS) pulses io_cfgErr and stays in IDLE.
  - LOAD (exactly 1 guard cycle):
    - io_layerCnt and io_BaseLayer show table[idx].
    - io_layerCfg is forced to 0 so no trigger counts while the descriptor changes.
    - Next state is RUN.
  - RUN:
    - io_layerCfg = table[idx].mask; the other outputs are held.
    - On io_layerEnd, if idx < numLayers-1: idx increments, go to LOAD.
    - On io_layerEnd, if idx = numLayers-1: loopCount increments (saturating at 2^CNT_W-1).
      - If latched loops != 0 and loopCount+1 == loops: go to DONE.
      - Otherwise idx=0, go to LOAD.
  - DONE (1 cycle): io_done=1, io_layerCfg=0, then go to IDLE.
- Output hold outside RUN:
  - io_layerIdx and io_loopCount keep their last values in IDLE after DONE or abort.
  - They are cleared only on the next accepted start.
- Latency:
  - io_layerEnd in RUN to the new descriptor on io_layerCnt: 1 cycle.
  - io_layerEnd in RUN to a nonzero io_layerCfg: 2 cycles.
- io_layerEnd outside RUN is ignored.
- io_abort:
  - In any non-IDLE state, go to IDLE next cycle with io_layerCfg=0.
  - No io_done pulse is produced.
  - Abort wins over a simultaneous io_layerEnd.
- Simultaneous io_start and io_abort in IDLE: start is taken.
- io_start while busy is ignored, with no error.
- A table entry with repeat=0 is passed through unchanged; the counter treats it as 1 repetition.
- The entry at index idx is read combinationally; table writes cannot collide with reads because writes are blocked while busy.

Test Plan:
1. Write 3 entries (mask 0x01/rep 2, mask 0x06/rep 1, mask 0x80/rep 3/base 1); numLayers=3, loops=1; start; pulse io_layerEnd in each RUN state. Required: idx sequence 0,1,2; io_layerCfg = 0 for exactly one cycle before each nonzero mask; io_done pulses once; io_loopCount=1; io_busy falls.
2. loops=2, numLayers=2. Required: idx sequence 0,1,0,1; done only after the 4th io_layerEnd; io_loopCount=2.
3. loops=0, numLayers=1; apply 5 io_layerEnd pulses, then io_abort. Required: io_loopCount=5; no io_done; IDLE the next cycle; io_layerCfg=0.
4. Start with numLayers=0 and separately numLayers=17. Required: io_cfgErr pulse; io_busy stays 0. A cfg write during RUN pulses io_cfgErr and leaves the entry unchanged (verified by a later run).
5. io_abort and io_layerEnd in the same cycle at the last layer of the last loop. Required: no io_done; IDLE.
6. Assert io_rst asynchronously mid-RUN. Required: all outputs 0 immediately, table cleared; after release, start with a zero table drives io_layerCfg=0 and io_layerCnt=0.
